// File: rtl/mips_isa_pkg.sv
// Shared MIPS ISA definitions for the control decoder and the instruction encoder:
// opcodes, instruction-kind codes and the loader FSM state encoding.
package mips_isa_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_JAL   = 6'b000011;
  localparam logic [5:0] OP_XORI  = 6'b001110;
  localparam logic [5:0] OP_SLTI  = 6'b001010;

  typedef enum logic [2:0] {
    KIND_R       = 3'd0,
    KIND_BEQ     = 3'd1,
    KIND_BNE     = 3'd2,
    KIND_ANDI    = 3'd3,
    KIND_JAL     = 3'd4,
    KIND_XORI    = 3'd5,
    KIND_SLTI    = 3'd6,
    KIND_ILLEGAL = 3'd7
  } instr_kind_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_FIN  = 2'd2
  } enc_state_e;

  // I-format word; the immediate is stored raw, extension is the decoder's job.
  function automatic logic [31:0] pack_itype(input logic [5:0] op, input logic [4:0] rs,
                                             input logic [4:0] rt, input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

endpackage

// File: rtl/mips_word_pack.sv
// Combinational packer: instruction kind plus raw fields into one 32-bit MIPS word,
// with a flag telling whether the kind is part of the supported subset.
module mips_word_pack
  import mips_isa_pkg::*;
(
  input  logic [2:0]  kind,
  input  logic [4:0]  rs,
  input  logic [4:0]  rt,
  input  logic [4:0]  rd,
  input  logic [5:0]  funct,
  input  logic [15:0] imm,
  input  logic [25:0] target,
  output logic [31:0] word,
  output logic        legal
);

  // Select the format by kind; unknown kinds produce a zero word and clear legal.
  always_comb begin
    word  = 32'h0000_0000;
    legal = 1'b1;
    case (instr_kind_e'(kind))
      KIND_R:    word = {OP_RTYPE, rs, rt, rd, 5'b00000, funct};
      KIND_BEQ:  word = pack_itype(OP_BEQ, rs, rt, imm);
      KIND_BNE:  word = pack_itype(OP_BNE, rs, rt, imm);
      KIND_ANDI: word = pack_itype(OP_ANDI, rs, rt, imm);
      KIND_JAL:  word = {OP_JAL, target};
      KIND_XORI: word = pack_itype(OP_XORI, rs, rt, imm);
      KIND_SLTI: word = pack_itype(OP_SLTI, rs, rt, imm);
      default: begin
        word  = 32'h0000_0000;
        legal = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/mips_instr_encoder.sv
// Streaming instruction loader: accepts decoded fields, packs them and writes one
// word per cycle into imem from a latched base address, with capacity and error tracking.
module mips_instr_encoder
  import mips_isa_pkg::*;
#(
  parameter int ADDR_W = 8,
  parameter int DEPTH  = 256
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [2:0]        in_kind,
  input  logic [4:0]        in_rs,
  input  logic [4:0]        in_rt,
  input  logic [4:0]        in_rd,
  input  logic [5:0]        in_funct,
  input  logic [15:0]       in_imm,
  input  logic [25:0]       in_target,
  input  logic              in_last,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic [ADDR_W:0]   count,
  output logic              busy,
  output logic              done,
  output logic              err
);

  localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W + 1)'(DEPTH);

  enc_state_e        state_r, state_s;
  logic [ADDR_W-1:0] base_r, base_s;
  logic [ADDR_W:0]   count_r, count_s, count_inc_s;
  logic              err_r, err_s;
  logic              we_r, we_s;
  logic [ADDR_W-1:0] addr_r;
  logic [31:0]       wdata_r;
  logic              ready_r, ready_s;
  logic              busy_r, busy_s;
  logic              done_r, done_s;
  logic [31:0]       word_s;
  logic              legal_s;
  logic              xfer_s;

  mips_word_pack u_pack (
    .kind   (in_kind),
    .rs     (in_rs),
    .rt     (in_rt),
    .rd     (in_rd),
    .funct  (in_funct),
    .imm    (in_imm),
    .target (in_target),
    .word   (word_s),
    .legal  (legal_s)
  );

  assign xfer_s      = (state_r == ST_LOAD) && in_valid && ready_r;
  assign count_inc_s = count_r + (ADDR_W + 1)'(1);

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next state: a last word or a filled memory ends the session through one FIN cycle.
  always_comb begin
    state_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (start) state_s = ST_LOAD;
        else       state_s = ST_IDLE;
      end
      ST_LOAD: begin
        if (xfer_s && (in_last || (legal_s && (count_inc_s == DEPTH_C)))) state_s = ST_FIN;
        else                                                            state_s = ST_LOAD;
      end
      ST_FIN:  state_s = ST_IDLE;
      default: state_s = ST_IDLE;
    endcase
  end

  // Next values of the session registers and of every registered output.
  always_comb begin
    base_s  = base_r;
    count_s = count_r;
    err_s   = err_r;
    we_s    = 1'b0;
    if ((state_r == ST_IDLE) && start) begin
      base_s  = base_addr;
      count_s = '0;
      err_s   = 1'b0;
    end else if (xfer_s) begin
      if (legal_s) begin
        we_s    = 1'b1;
        count_s = count_inc_s;
      end else begin
        err_s = 1'b1;
      end
    end else begin
      we_s = 1'b0;
    end
    ready_s = (state_s == ST_LOAD) && (count_s < DEPTH_C);
    busy_s  = (state_s == ST_LOAD);
    done_s  = (state_s == ST_FIN);
  end

  // Output and datapath registers; the write address is computed from the pre-increment count.
  always_ff @(posedge clk) begin
    if (rst) begin
      base_r  <= '0;
      count_r <= '0;
      err_r   <= 1'b0;
      we_r    <= 1'b0;
      addr_r  <= '0;
      wdata_r <= 32'h0000_0000;
      ready_r <= 1'b0;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      base_r  <= base_s;
      count_r <= count_s;
      err_r   <= err_s;
      we_r    <= we_s;
      ready_r <= ready_s;
      busy_r  <= busy_s;
      done_r  <= done_s;
      if (we_s) begin
        addr_r  <= base_r + count_r[ADDR_W-1:0];
        wdata_r <= word_s;
      end else begin
        addr_r  <= addr_r;
        wdata_r <= wdata_r;
      end
    end
  end

  assign in_ready   = ready_r;
  assign imem_we    = we_r;
  assign imem_addr  = addr_r;
  assign imem_wdata = wdata_r;
  assign count      = count_r;
  assign busy       = busy_r;
  assign done       = done_r;
  assign err        = err_r;

endmodule

// File: tb/tb_mips_instr_encoder.sv
// Directed bench for mips_instr_encoder: a default-size instance and a DEPTH=4
// instance for the capacity case, all expectations hand-computed.
module tb_mips_instr_encoder;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        start4 = 1'b0;
  logic [7:0]  base_addr = 8'h00;
  logic        in_valid = 1'b0;
  logic [2:0]  in_kind = 3'd0;
  logic [4:0]  in_rs = 5'd0, in_rt = 5'd0, in_rd = 5'd0;
  logic [5:0]  in_funct = 6'd0;
  logic [15:0] in_imm = 16'h0000;
  logic [25:0] in_target = 26'h0;
  logic        in_last = 1'b0;

  logic        in_ready, imem_we, busy, done, err;
  logic [7:0]  imem_addr;
  logic [31:0] imem_wdata;
  logic [8:0]  count;

  logic        in_ready4, imem_we4, busy4, done4, err4;
  logic [7:0]  imem_addr4;
  logic [31:0] imem_wdata4;
  logic [8:0]  count4;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  mips_instr_encoder #(.ADDR_W(8), .DEPTH(256)) dut (
    .clk(clk), .rst(rst), .start(start), .base_addr(base_addr),
    .in_valid(in_valid), .in_ready(in_ready), .in_kind(in_kind),
    .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd), .in_funct(in_funct),
    .in_imm(in_imm), .in_target(in_target), .in_last(in_last),
    .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
    .count(count), .busy(busy), .done(done), .err(err)
  );

  mips_instr_encoder #(.ADDR_W(8), .DEPTH(4)) dut4 (
    .clk(clk), .rst(rst), .start(start4), .base_addr(base_addr),
    .in_valid(in_valid), .in_ready(in_ready4), .in_kind(in_kind),
    .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd), .in_funct(in_funct),
    .in_imm(in_imm), .in_target(in_target), .in_last(in_last),
    .imem_we(imem_we4), .imem_addr(imem_addr4), .imem_wdata(imem_wdata4),
    .count(count4), .busy(busy4), .done(done4), .err(err4)
  );

  task automatic check_value(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic begin_session(input logic [7:0] base);
    base_addr = base;
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  // Offer one word for a single cycle; outputs are examined right after the edge.
  task automatic send(input logic [2:0] kind, input logic [4:0] rs, input logic [4:0] rt,
                      input logic [4:0] rd, input logic [5:0] funct, input logic [15:0] imm,
                      input logic [25:0] target, input logic last);
    in_kind = kind; in_rs = rs; in_rt = rt; in_rd = rd; in_funct = funct;
    in_imm = imm; in_target = target; in_last = last; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic expect_write(input string tag, input logic [7:0] addr, input logic [31:0] wdata);
    check_value({tag, "_we"}, {31'd0, imem_we}, 32'd1);
    check_value({tag, "_addr"}, {24'd0, imem_addr}, {24'd0, addr});
    check_value({tag, "_wdata"}, imem_wdata, wdata);
  endtask

  initial begin
    int nwr;
    int ndone;

    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    step();
    check_value("rst_ready", {31'd0, in_ready}, 32'd0);
    check_value("rst_we", {31'd0, imem_we}, 32'd0);
    check_value("rst_addr", {24'd0, imem_addr}, 32'd0);
    check_value("rst_wdata", imem_wdata, 32'd0);
    check_value("rst_count", {23'd0, count}, 32'd0);
    check_value("rst_busy", {31'd0, busy}, 32'd0);
    check_value("rst_done", {31'd0, done}, 32'd0);
    check_value("rst_err", {31'd0, err}, 32'd0);

    // Valid held while idle: nothing is accepted.
    for (int i = 0; i < 3; i++) begin
      send(3'd0, 5'd1, 5'd2, 5'd3, 6'h20, 16'h0, 26'h0, 1'b0);
      check_value("idle_we", {31'd0, imem_we}, 32'd0);
      check_value("idle_ready", {31'd0, in_ready}, 32'd0);
    end

    // R-type single-word session.
    begin_session(8'h10);
    check_value("s1_busy", {31'd0, busy}, 32'd1);
    check_value("s1_ready", {31'd0, in_ready}, 32'd1);
    send(3'd0, 5'd1, 5'd2, 5'd3, 6'h20, 16'h0, 26'h0, 1'b1);
    expect_write("rtype", 8'h10, 32'h0022_1820);
    check_value("rtype_count", {23'd0, count}, 32'd1);
    check_value("rtype_done", {31'd0, done}, 32'd1);
    step();
    check_value("rtype_done_off", {31'd0, done}, 32'd0);
    check_value("rtype_we_off", {31'd0, imem_we}, 32'd0);

    // beq then andi back-to-back, the second marked last.
    begin_session(8'h20);
    send(3'd1, 5'd1, 5'd2, 5'd0, 6'h0, 16'hFFFF, 26'h0, 1'b0);
    expect_write("beq", 8'h20, 32'h1022_FFFF);
    check_value("beq_done", {31'd0, done}, 32'd0);
    send(3'd3, 5'd4, 5'd5, 5'd0, 6'h0, 16'h00FF, 26'h0, 1'b1);
    expect_write("andi", 8'h21, 32'h3085_00FF);
    check_value("andi_done", {31'd0, done}, 32'd1);
    check_value("andi_busy", {31'd0, busy}, 32'd0);
    step();
    check_value("andi_done_once", {31'd0, done}, 32'd0);
    check_value("andi_busy_after", {31'd0, busy}, 32'd0);
    check_value("andi_count", {23'd0, count}, 32'd2);

    // jal, an illegal kind mid-stream, then xori as last.
    begin_session(8'h30);
    send(3'd4, 5'd0, 5'd0, 5'd0, 6'h0, 16'h0, 26'h010_0000, 1'b0);
    expect_write("jal", 8'h30, 32'h0C10_0000);
    send(3'd7, 5'd1, 5'd1, 5'd1, 6'h0, 16'h0, 26'h0, 1'b0);
    check_value("ill_we", {31'd0, imem_we}, 32'd0);
    check_value("ill_err", {31'd0, err}, 32'd1);
    check_value("ill_count", {23'd0, count}, 32'd1);
    check_value("ill_busy", {31'd0, busy}, 32'd1);
    send(3'd5, 5'd6, 5'd7, 5'd0, 6'h0, 16'h1234, 26'h0, 1'b1);
    expect_write("xori", 8'h31, 32'h38C7_1234);
    check_value("xori_err_sticky", {31'd0, err}, 32'd1);
    check_value("xori_count", {23'd0, count}, 32'd2);
    step();

    // Address wrap from 0xFF; start during LOAD must be ignored; err cleared by start.
    begin_session(8'hFF);
    check_value("wrap_err_clr", {31'd0, err}, 32'd0);
    send(3'd2, 5'd2, 5'd3, 5'd0, 6'h0, 16'h8000, 26'h0, 1'b0);
    expect_write("bne", 8'hFF, 32'h1443_8000);
    start = 1'b1;
    base_addr = 8'h55;
    send(3'd6, 5'd31, 5'd0, 5'd0, 6'h0, 16'h7FFF, 26'h0, 1'b1);
    start = 1'b0;
    expect_write("slti", 8'h00, 32'h2BE0_7FFF);
    step();
    check_value("fin_start_ignored", {31'd0, busy}, 32'd0);

    // Illegal word carrying last still ends the session.
    begin_session(8'h40);
    send(3'd7, 5'd0, 5'd0, 5'd0, 6'h0, 16'h0, 26'h0, 1'b1);
    check_value("ill_last_we", {31'd0, imem_we}, 32'd0);
    check_value("ill_last_done", {31'd0, done}, 32'd1);
    check_value("ill_last_err", {31'd0, err}, 32'd1);
    check_value("ill_last_count", {23'd0, count}, 32'd0);
    step();

    // Capacity: DEPTH=4 instance offered five words with no last marker.
    base_addr = 8'h08;
    start4 = 1'b1;
    step();
    start4 = 1'b0;
    nwr = 0;
    ndone = 0;
    in_kind = 3'd0; in_rs = 5'd1; in_rt = 5'd2; in_rd = 5'd3; in_funct = 6'h20;
    in_last = 1'b0;
    in_valid = 1'b1;
    for (int c = 0; c < 8; c++) begin
      step();
      if (imem_we4) begin
        check_value("full_addr", {24'd0, imem_addr4}, 32'h08 + nwr);
        check_value("full_wdata", imem_wdata4, 32'h0022_1820);
        nwr++;
      end
      if (done4) ndone++;
      if (nwr == 5) break;
    end
    check_value("full_writes", nwr, 32'd4);
    check_value("full_done", ndone, 32'd1);
    check_value("full_ready", {31'd0, in_ready4}, 32'd0);
    check_value("full_count", {23'd0, count4}, 32'd4);
    check_value("full_main_we", {31'd0, imem_we}, 32'd0);
    in_valid = 1'b0;
    step();

    // Reset mid-session, coinciding with a transfer: the pending write is dropped.
    begin_session(8'h50);
    send(3'd0, 5'd1, 5'd2, 5'd3, 6'h20, 16'h0, 26'h0, 1'b0);
    expect_write("pre_rst", 8'h50, 32'h0022_1820);
    rst = 1'b1;
    send(3'd0, 5'd4, 5'd5, 5'd6, 6'h21, 16'h0, 26'h0, 1'b0);
    rst = 1'b0;
    check_value("mrst_we", {31'd0, imem_we}, 32'd0);
    check_value("mrst_addr", {24'd0, imem_addr}, 32'd0);
    check_value("mrst_wdata", imem_wdata, 32'd0);
    check_value("mrst_count", {23'd0, count}, 32'd0);
    check_value("mrst_busy", {31'd0, busy}, 32'd0);
    check_value("mrst_ready", {31'd0, in_ready}, 32'd0);
    step();
    check_value("mrst_no_done", {31'd0, done}, 32'd0);
    check_value("mrst_we2", {31'd0, imem_we}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
